// File: rtl/serial_word_adder_pkg.sv
// Shared types and defaults for the bit-serial word adder.
package serial_word_adder_pkg;

    localparam int unsigned SWA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } swa_state_t;

endpackage

// File: rtl/serial_bit_adder.sv
// One-bit full adder with a registered carry, used LSB-first by the word adder.
module serial_bit_adder (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry_out
);

    logic r_carry;
    logic w_half;

    assign w_half    = a ^ b;
    assign sum       = w_half ^ r_carry;
    // carry_out is the combinational carry of this bit, i.e. what r_carry takes next
    assign carry_out = (a & b) | (r_carry & w_half);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_carry <= 1'b0;
        end else if (en) begin
            r_carry <= carry_out;
        end
    end

endmodule

// File: rtl/serial_word_adder.sv
// Bit-serial unsigned adder: accepts two WIDTH-bit words, adds them one bit per
// cycle, and presents the WIDTH+1-bit sum with a valid/ready handshake.
module serial_word_adder
    import serial_word_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SWA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   sum_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    swa_state_t       r_state;
    swa_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_shift;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_shift;
    logic             w_last;
    logic             w_sum_bit;
    logic             w_carry;

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);
    assign sum_data   = {r_cout, r_res};

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_shift    = (r_state == ST_SHIFT);
    assign w_last     = w_shift & (r_cnt == LAST_CNT);

    serial_bit_adder u_bit_adder (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_in_fire),
        .en        (w_shift),
        .a         (r_a[0]),
        .b         (r_b[0]),
        .sum       (w_sum_bit),
        .carry_out (w_carry)
    );

    // New sum bit enters at the top; after WIDTH shifts bit 0 reaches r_res[0].
    always_comb begin
        w_res_shift            = r_res >> 1;
        w_res_shift[WIDTH-1]   = w_sum_bit;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_in_fire)  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last)     w_state_nxt = ST_DONE;
            ST_DONE:  if (w_out_fire) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_fire) begin
                r_a   <= a_data;
                r_b   <= b_data;
                r_cnt <= '0;
            end else if (w_shift) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= w_res_shift;
                r_cnt <= r_cnt + CNT_ONE;
                if (w_last) begin
                    r_cout <= w_carry;
                end
            end
        end
    end

endmodule
